// File: rtl/sram_arbiter.sv
// N-client arbiter in front of the single SRAM controller: picks one eligible
// request, issues a one-cycle read/write strobe, waits for completion, acks.
module sram_arbiter #(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RR_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CLIENTS-1:0]          client_en,
  input  logic [N_CLIENTS-1:0]          req_valid,
  input  logic [N_CLIENTS-1:0]          req_we,
  input  logic [N_CLIENTS*ADDR_W-1:0]   req_addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   req_wdata,
  output logic [N_CLIENTS-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [ADDR_W-1:0]             sram_address,
  output logic [DATA_W-1:0]             sram_data_write,
  output logic                          sram_read,
  output logic                          sram_write,
  input  logic                          sram_ready,
  input  logic [DATA_W-1:0]             sram_data_read
);

  localparam int unsigned ID_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [N_CLIENTS-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  we_q, we_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  wb_cnt_q, wb_cnt_d;

  logic [7:0]            elig;
  logic                  found;
  logic [ID_W-1:0]       win;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_we;

  // k-th candidate in search order: from ptr upward in round-robin, else from 0
  function automatic logic [ID_W-1:0] cand(input logic [ID_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = (RR_MODE != 0) ? 32'(p) + k : k;
    return ID_W'(s % N_CLIENTS);
  endfunction

  // Winner selection and payload mux
  always_comb begin
    elig      = 8'(req_valid & client_en);
    found     = 1'b0;
    win       = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      if (!found && elig[cand(ptr_q, k)]) begin
        found = 1'b1;
        win   = cand(ptr_q, k);
      end
    end
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (ID_W'(i) == win) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_we    = req_we[i];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    grant_id_d = grant_id_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    read_d     = 1'b0;
    write_d    = 1'b0;
    we_d       = we_q;
    ptr_d      = ptr_q;
    wb_cnt_d   = wb_cnt_q;
    case (state_q)
      IDLE: begin
        // ack cycle is skipped: the acked client's req_valid is still stale-high
        if (found && sram_ready && ack_q == '0) begin
          grant_id_d = win;
          address_d  = sel_addr;
          wdata_d    = sel_wdata;
          we_d       = sel_we;
          write_d    = sel_we;
          read_d     = ~sel_we;
          ptr_d      = (win == ID_W'(N_CLIENTS - 1)) ? '0 : win + ID_W'(1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wb_cnt_d = 1'b0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // controllers that never drop ready are let through after two cycles
        if (!sram_ready || wb_cnt_q) state_d = WAIT_DONE;
        else                         wb_cnt_d = 1'b1;
      end
      WAIT_DONE: begin
        if (sram_ready) begin
          ack_d = N_CLIENTS'(8'h01 << grant_id_q);
          if (!we_q) rdata_d = sram_data_read;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      rdata_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      we_q       <= 1'b0;
      ptr_q      <= '0;
      wb_cnt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      read_q     <= read_d;
      write_q    <= write_d;
      we_q       <= we_d;
      ptr_q      <= ptr_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign ack             = ack_q;
  assign rdata           = rdata_q;
  assign grant_id        = grant_id_q;
  assign busy            = busy_q;
  assign sram_address    = address_q;
  assign sram_data_write = wdata_q;
  assign sram_read       = read_q;
  assign sram_write      = write_q;

endmodule
